ext_unit_arbiter: RTL and testbench

//  Shares one immediate-extension datapath (16->32 sign/zero/LUI/branch-offset)

---
 rtl/ext_unit_arbiter.sv | 118 +++++++++++
 tb/tb_ext_unit_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_unit_arbiter.sv
// ext_unit_arbiter: shares one 16->32 immediate-extension datapath between the
// ID-stage immediate path (req0) and the branch-target unit (req1).
// Uses round-robin arbitration and a one-entry registered result.
//
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   reqN_valid_i/data_i/mode_i        requester N immediate + extension mode
//   reqN_ready_o                      requester N transfer accepted (combinational)
//   rsp_valid_o/data_o/id_o           registered result, its owner index
//   rsp_ready_i                       consumer takes result this cycle
//
// Modes: 00 SEXT, 01 ZEXT, 10 LUI, 11 BOFF (SEXT << 2).
module ext_unit_arbiter #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  input  logic [IN_W-1:0]  req0_data_i,
  input  logic [1:0]       req0_mode_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [IN_W-1:0]  req1_data_i,
  input  logic [1:0]       req1_mode_i,
  output logic             req1_ready_o,
  output logic             rsp_valid_o,
  output logic [OUT_W-1:0] rsp_data_o,
  output logic             rsp_id_o,
  input  logic             rsp_ready_i
);

  localparam int unsigned EXT_W = OUT_W - IN_W;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;

  logic             grant0, grant1;
  logic             accept_ok;
  logic             xfer0, xfer1;

  // Extension of the granted raw immediate.
  function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d,
                                              input logic [1:0]      mode);
    logic [OUT_W-1:0] sext;
    sext = {{EXT_W{d[IN_W-1]}}, d};
    case (mode)
      2'b00:   extend = sext;
      2'b01:   extend = {{EXT_W{1'b0}}, d};
      2'b10:   extend = {d, {EXT_W{1'b0}}};
      default: extend = sext << 2;
    endcase
  endfunction

  // State register and result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Arbitration, handshake and next-state logic.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;

    // A contested grant goes to the requester that did not win last.
    grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
    grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);

    // A full register that is draining this cycle can be refilled on the same edge.
    accept_ok    = (state_q == EMPTY) | ((state_q == FULL) & rsp_ready_i);
    req0_ready_o = ~rst_i & accept_ok & grant0;
    req1_ready_o = ~rst_i & accept_ok & grant1;

    xfer0 = req0_valid_i & req0_ready_o;
    xfer1 = req1_valid_i & req1_ready_o;

    case (state_q)
      EMPTY: begin
        if (xfer0 | xfer1) state_d = FULL;
      end
      FULL: begin
        if (rsp_ready_i & ~(xfer0 | xfer1)) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    if (xfer0) begin
      data_d       = extend(req0_data_i, req0_mode_i);
      id_d         = 1'b0;
      last_grant_d = 1'b0;
    end else if (xfer1) begin
      data_d       = extend(req1_data_i, req1_mode_i);
      id_d         = 1'b1;
      last_grant_d = 1'b1;
    end
  end

  assign rsp_valid_o = (state_q == FULL);
  assign rsp_data_o  = data_q;
  assign rsp_id_o    = id_q;

endmodule

// File: tb/tb_ext_unit_arbiter.sv
// Directed testbench for ext_unit_arbiter.
module tb_ext_unit_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_valid_i, req1_valid_i;
  logic [15:0] req0_data_i, req1_data_i;
  logic [1:0]  req0_mode_i, req1_mode_i;
  logic        req0_ready_o, req1_ready_o;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_id_o;
  logic        rsp_ready_i;

  int n_checks = 0;
  int n_fail   = 0;

  ext_unit_arbiter #(.IN_W(16), .OUT_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req0_valid_i (req0_valid_i),
    .req0_data_i  (req0_data_i),
    .req0_mode_i  (req0_mode_i),
    .req0_ready_o (req0_ready_o),
    .req1_valid_i (req1_valid_i),
    .req1_data_i  (req1_data_i),
    .req1_mode_i  (req1_mode_i),
    .req1_ready_o (req1_ready_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .rsp_id_o     (rsp_id_o),
    .rsp_ready_i  (rsp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid_i = 1'b0; req0_data_i = '0; req0_mode_i = '0;
    req1_valid_i = 1'b0; req1_data_i = '0; req1_mode_i = '0;
    rsp_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (rsp_valid_o !== 1'b0 || rsp_data_o !== 32'h0 || rsp_id_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b data=%h id=%b required 0/00000000/0", rsp_valid_o, rsp_data_o, rsp_id_o);
    end
    // Fill, hold with backpressure, then reset asynchronously mid-cycle.
    req0_valid_i = 1'b1; req0_data_i = 16'h5555; req0_mode_i = 2'b01;
    step();
    req0_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid_o !== 1'b0 || rsp_data_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b data=%h required 0/00000000", rsp_valid_o, rsp_data_o);
    end
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    #1;
    n_checks++;
    if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_in_reset: r0=%b r1=%b required 0/0", req0_ready_o, req1_ready_o);
    end
    step();
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL first_contested: r0=%b r1=%b required 1/0", req0_ready_o, req1_ready_o);
    end
    idle_inputs();
  endtask

  task automatic test_modes();
    logic [31:0] exp_data [4];
    exp_data[0] = 32'hFFFF8001;
    exp_data[1] = 32'h00008001;
    exp_data[2] = 32'h80010000;
    exp_data[3] = 32'hFFFE0004;
    do_reset();
    rsp_ready_i = 1'b1;
    req0_valid_i = 1'b1; req0_data_i = 16'h8001;
    for (int m = 0; m < 4; m++) begin
      req0_mode_i = 2'(m);
      #1;
      n_checks++;
      if (req0_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL mode%0d_ready: got %b required 1", m, req0_ready_o);
      end
      step();
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== exp_data[m] || rsp_id_o !== 1'b0) begin
        n_fail++;
        $display("FAIL mode%0d_result: valid=%b data=%h id=%b required 1/%h/0", m, rsp_valid_o, rsp_data_o, rsp_id_o, exp_data[m]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic        exp_id;
    logic [31:0] exp_data;
    do_reset();
    rsp_ready_i  = 1'b1;
    req0_valid_i = 1'b1; req0_data_i = 16'h0010; req0_mode_i = 2'b01;
    req1_valid_i = 1'b1; req1_data_i = 16'hF020; req1_mode_i = 2'b00;
    for (int i = 0; i < 6; i++) begin
      exp_id   = 1'(i % 2);
      exp_data = exp_id ? 32'hFFFFF020 : 32'h00000010;
      #1;
      n_checks++;
      if (req0_ready_o !== ~exp_id || req1_ready_o !== exp_id) begin
        n_fail++;
        $display("FAIL rr_grant%0d: r0=%b r1=%b required %b/%b", i, req0_ready_o, req1_ready_o, ~exp_id, exp_id);
      end
      step();
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== exp_id || rsp_data_o !== exp_data) begin
        n_fail++;
        $display("FAIL rr_result%0d: valid=%b id=%b data=%h required 1/%b/%h", i, rsp_valid_o, rsp_id_o, rsp_data_o, exp_id, exp_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid_i = 1'b1; req0_data_i = 16'h1234; req0_mode_i = 2'b01;
    step();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; req1_data_i = 16'hABCD; req1_mode_i = 2'b01;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++;
      if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h00001234 || rsp_id_o !== 1'b0 ||
          req0_ready_o !== 1'b0 || req1_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b data=%h id=%b r0=%b r1=%b required 1/00001234/0/0/0",
                 i, rsp_valid_o, rsp_data_o, rsp_id_o, req0_ready_o, req1_ready_o);
      end
      step();
    end
    rsp_ready_i = 1'b1;
    #1;
    n_checks++;
    if (req1_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: r1=%b required 1", req1_ready_o);
    end
    step();
    req1_valid_i = 1'b0;
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h0000ABCD || rsp_id_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_refill: valid=%b data=%h id=%b required 1/0000abcd/1", rsp_valid_o, rsp_data_o, rsp_id_o);
    end
    step();
    n_checks++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain_empty: valid=%b required 0", rsp_valid_o);
    end
    idle_inputs();
  endtask

  task automatic test_single_requester();
    do_reset();
    rsp_ready_i  = 1'b1;
    req1_valid_i = 1'b1; req1_data_i = 16'h7FFF; req1_mode_i = 2'b00;
    #1;
    n_checks++;
    if (req1_ready_o !== 1'b1 || req0_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: r0=%b r1=%b required 0/1", req0_ready_o, req1_ready_o);
    end
    step();
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_data_o !== 32'h00007FFF || rsp_id_o !== 1'b1) begin
      n_fail++;
      $display("FAIL single_result: valid=%b data=%h id=%b required 1/00007fff/1", rsp_valid_o, rsp_data_o, rsp_id_o);
    end
    req0_valid_i = 1'b1; req0_data_i = 16'h0003; req0_mode_i = 2'b11;
    #1;
    n_checks++;
    if (req0_ready_o !== 1'b1 || req1_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_then_both: r0=%b r1=%b required 1/0", req0_ready_o, req1_ready_o);
    end
    step();
    n_checks++;
    if (rsp_id_o !== 1'b0 || rsp_data_o !== 32'h0000000C) begin
      n_fail++;
      $display("FAIL single_then_both_result: id=%b data=%h required 0/0000000c", rsp_id_o, rsp_data_o);
    end
    idle_inputs();
  endtask

  task automatic test_withdraw();
    do_reset();
    req0_valid_i = 1'b1; req0_data_i = 16'h0001; req0_mode_i = 2'b01;
    step();
    req0_valid_i = 1'b0;
    req1_valid_i = 1'b1; req1_data_i = 16'h00EE; req1_mode_i = 2'b01;
    step();
    step();
    req1_valid_i = 1'b0;
    rsp_ready_i  = 1'b1;
    step();
    n_checks++;
    if (rsp_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL withdraw_no_result: valid=%b id=%b data=%h required valid 0", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    // Last actual grant was req0, so the next contested grant goes to req1.
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    #1;
    n_checks++;
    if (req0_ready_o !== 1'b0 || req1_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL withdraw_order: r0=%b r1=%b required 0/1", req0_ready_o, req1_ready_o);
    end
    step();
    n_checks++;
    if (rsp_valid_o !== 1'b1 || rsp_id_o !== 1'b1 || rsp_data_o !== 32'h000000EE) begin
      n_fail++;
      $display("FAIL withdraw_result: valid=%b id=%b data=%h required 1/1/000000ee", rsp_valid_o, rsp_id_o, rsp_data_o);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_modes();
    test_round_robin();
    test_backpressure();
    test_single_requester();
    test_withdraw();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
